// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin packet arbiter steering an N:1 data mux into a one-entry output register
module mux_rr_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          req_valid_i,
    input  logic [N*WIDTH-1:0]    req_data_i,
    input  logic [N-1:0]          req_last_i,
    output logic [N-1:0]          req_ready_o,
    output logic                  out_valid_o,
    output logic [WIDTH-1:0]      out_data_o,
    output logic                  out_last_o,
    input  logic                  out_ready_i,
    output logic [N-1:0]          grant_o,
    output logic [$clog2(N)-1:0]  grant_idx_o
);
    localparam int IW = $clog2(N);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;

    logic [IW-1:0]    pick;
    logic             found;
    int               scan;
    logic             slot_free;
    logic             accept;
    logic             own_last;
    logic [WIDTH-1:0] own_data;

    // the output slot can take a beat when empty or being drained this cycle
    assign slot_free   = !out_valid_q || out_ready_i;
    // grant is zero in IDLE, so only the owner in BUSY ever sees ready
    assign req_ready_o = grant_q & {N{slot_free}};
    assign accept      = |(req_valid_i & req_ready_o);
    assign own_last    = req_last_i[idx_q];
    assign own_data    = req_data_i[idx_q*WIDTH +: WIDTH];

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign grant_o     = grant_q;
    assign grant_idx_o = idx_q;

    // pick the first requesting index scanning cyclically upward from ptr+1
    always_comb begin
        pick  = '0;
        found = 1'b0;
        scan  = 0;
        for (int k = 1; k <= N; k++) begin
            scan = (int'(ptr_q) + k) % N;
            if (!found && req_valid_i[scan]) begin
                found = 1'b1;
                pick  = scan[IW-1:0];
            end
        end
    end

    // next state: arbitrate in IDLE, hold the lock until the owner's last beat, load or drain the output slot
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (state_q == IDLE) begin
            if (found) begin
                state_d = BUSY;
                grant_d = N'(1) << pick;
                idx_d   = pick;
            end
        end else if (accept && own_last) begin
            state_d = IDLE;
            ptr_d   = idx_q;
            grant_d = '0;
        end
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = own_data;
            out_last_d  = own_last;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // state registers; reset drops any partial packet and gives requester 0 first priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= IW'(N-1);
            grant_q     <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end
endmodule
